// File: rtl/adc8_conv_sequencer.sv
// CONVST/EOC handshake master for an 8-bit parallel ADC: periodic conversion start,
// EOC-synchronized capture, block averaging, plus sticky timeout/overrun flags.
module adc8_conv_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CONVST_WIDTH  = 10,
    parameter int TIMEOUT       = 500,
    parameter int AVG_LOG2      = 2,
    parameter int N_BIT         = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_enable,
    input  logic [N_BIT-1:0] i_ADC_DATA,
    input  logic             i_EOC,
    output logic             o_CONVST,
    output logic [N_BIT-1:0] o_data,
    output logic             o_valid,
    output logic [N_BIT-1:0] o_avg,
    output logic             o_avg_valid,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_overrun
);
    localparam int PW       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int STEP_MAX = (CONVST_WIDTH > TIMEOUT) ? CONVST_WIDTH : TIMEOUT;
    localparam int SW       = $clog2(STEP_MAX + 1);
    localparam int AW       = N_BIT + AVG_LOG2;
    localparam int CW       = AVG_LOG2 + 1;
    localparam logic [CW-1:0] BLOCK = CW'(1 << AVG_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_EOC, S_CAPTURE} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [PW-1:0]     per_q, per_d;
    logic              eoc_s1_q, eoc_s2_q, eoc_prev_q;
    logic [AW-1:0]     acc_q, acc_d, sum;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [N_BIT-1:0]  data_q, avg_q, avg_d;
    logic              conv_q, valid_q, avg_vld_q, avg_vld_d, busy_q;
    logic              timeout_q, timeout_d, overrun_q, overrun_d;
    logic              tick, eoc_fall, capture;

    assign tick     = i_enable && (per_q == '0);
    assign eoc_fall = eoc_prev_q && !eoc_s2_q;
    assign per_d    = (!i_enable || per_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : per_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        step_d    = (state_q == S_IDLE) ? '0 : step_q + 1'b1;
        timeout_d = timeout_q;
        overrun_d = overrun_q | (tick & (state_q != S_IDLE));
        capture   = 1'b0;
        if (!i_enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:     if (tick) state_d = S_START;
                S_START:    if (step_q == SW'(CONVST_WIDTH - 1)) state_d = S_WAIT_EOC;
                S_WAIT_EOC: begin
                    // A falling edge on the final wait cycle still counts as a conversion.
                    if (eoc_fall) begin
                        state_d = S_CAPTURE;
                    end else if (step_q == SW'(TIMEOUT - 1)) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end
                end
                S_CAPTURE: begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != state_q) step_d = '0;

        sum       = acc_q + AW'(i_ADC_DATA);
        cnt_inc   = cnt_q + 1'b1;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        if (!i_enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (capture) begin
            if (cnt_inc == BLOCK) begin
                avg_d     = sum[AW-1:AVG_LOG2];
                avg_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            per_q      <= '0;
            eoc_s1_q   <= 1'b1;
            eoc_s2_q   <= 1'b1;
            eoc_prev_q <= 1'b1;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            avg_q      <= '0;
            conv_q     <= 1'b0;
            valid_q    <= 1'b0;
            avg_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            per_q      <= per_d;
            eoc_s1_q   <= i_EOC;
            eoc_s2_q   <= eoc_s1_q;
            eoc_prev_q <= eoc_s2_q;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            if (capture) data_q <= i_ADC_DATA;
            avg_q      <= avg_d;
            conv_q     <= (state_d == S_START);
            valid_q    <= capture;
            avg_vld_q  <= avg_vld_d;
            busy_q     <= (state_d != S_IDLE);
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_CONVST    = conv_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_avg       = avg_q;
    assign o_avg_valid = avg_vld_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_adc8_conv_sequencer.sv
// Bench: instance A uses default timing, instance B a short period with AVG_LOG2=0
// so a tick can land while a conversion is still waiting for EOC.
module tb_adc8_conv_sequencer;
    localparam int CW  = 10;
    localparam int TO  = 500;
    localparam int PER = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_en, a_eoc, a_convst, a_valid, a_avg_valid, a_busy, a_to, a_ovr;
    logic [7:0] a_adc, a_data, a_avg;
    logic       b_en, b_eoc, b_convst, b_valid, b_avg_valid, b_busy, b_to, b_ovr;
    logic [7:0] b_adc, b_data, b_avg;

    adc8_conv_sequencer u_a (
        .i_CLK(clk), .i_RST(rst), .i_enable(a_en), .i_ADC_DATA(a_adc), .i_EOC(a_eoc),
        .o_CONVST(a_convst), .o_data(a_data), .o_valid(a_valid), .o_avg(a_avg),
        .o_avg_valid(a_avg_valid), .o_busy(a_busy), .o_timeout(a_to), .o_overrun(a_ovr)
    );

    adc8_conv_sequencer #(.SAMPLE_PERIOD(200), .AVG_LOG2(0)) u_b (
        .i_CLK(clk), .i_RST(rst), .i_enable(b_en), .i_ADC_DATA(b_adc), .i_EOC(b_eoc),
        .o_CONVST(b_convst), .o_data(b_data), .o_valid(b_valid), .o_avg(b_avg),
        .o_avg_valid(b_avg_valid), .o_busy(b_busy), .o_timeout(b_to), .o_overrun(b_ovr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: expected samples in order, and the current partial averaging block.
    logic [7:0] exp_q[$];
    logic [7:0] blk[$];
    int         vcnt = 0;
    int         last_avg = 0;
    logic [7:0] last_dat = 8'h00;

    initial begin
        logic [7:0] e;
        int         s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (a_valid) begin
                    vcnt++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", a_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", a_data, e);
                        blk.push_back(e);
                        if (blk.size() == 4) begin
                            s = 0;
                            foreach (blk[i]) s += blk[i];
                            last_avg = s / 4;
                            chk("avg_valid", a_avg_valid, 1);
                            chk("avg", a_avg, last_avg);
                            blk.delete();
                        end else begin
                            chk("avg_valid_early", a_avg_valid, 0);
                        end
                    end
                end else if (a_avg_valid) begin
                    chk("avg_valid_alone", a_avg_valid, 0);
                end
            end
        end
    end

    task automatic wait_rise_a(output int r);
        logic last;
        logic found;
        int   n;
        last  = a_convst;
        found = 1'b0;
        n     = 0;
        r     = cyc;
        while (!found && n < 2 * PER) begin
            @(negedge clk);
            n++;
            if (a_convst && !last) begin
                found = 1'b1;
                r     = cyc;
            end
            last = a_convst;
        end
        chk("convst_rise_seen", found, 1);
    endtask

    // One ADC conversion on A: EOC falls d cycles after CONVST rises, with data dat.
    task automatic conv_a(input int rk, input int d, input logic [7:0] dat, output int r);
        if (rk >= 0) r = rk;
        else wait_rise_a(r);
        chk("busy_at_convst", a_busy, 1);
        while (cyc < r + CW - 1) @(negedge clk);
        chk("convst_high", a_convst, 1);
        @(negedge clk);
        chk("convst_width", a_convst, 0);
        while (cyc < r + d) @(negedge clk);
        a_adc = dat;
        a_eoc = 1'b0;
        exp_q.push_back(dat);
        last_dat = dat;
        repeat (3) @(negedge clk);
        chk("valid_early", a_valid, 0);
        @(negedge clk);
        chk("valid_latency", a_valid, 1);
        @(negedge clk);
        chk("valid_one_cycle", a_valid, 0);
        a_eoc = 1'b1;
    endtask

    initial begin
        int         r, r1, r2, v0;
        logic [7:0] any, bd;
        logic [7:0] blk200[4];
        a_en = 1'b1; a_eoc = 1'b0; a_adc = 8'h00;
        b_en = 1'b0; b_eoc = 1'b1; b_adc = 8'h00;
        blk200[0] = 8'd200; blk200[1] = 8'd200; blk200[2] = 8'd200; blk200[3] = 8'd201;

        any = 8'h00;
        repeat (20) begin
            @(negedge clk);
            any |= {a_convst, a_valid, a_avg_valid, a_busy, a_to, a_ovr, |a_data, |a_avg};
        end
        chk("reset_outputs", any, 0);

        rst = 1'b0;
        @(negedge clk);
        chk("first_convst", a_convst, 1);
        a_eoc = 1'b1;
        conv_a(cyc, 300, 8'h5A, r1);
        chk("data_5a", a_data, 8'h5A);
        conv_a(-1, $urandom_range(400, 20), 8'($urandom), r2);
        chk("spacing", r2 - r1, PER);
        for (int i = 0; i < 2; i++) conv_a(-1, $urandom_range(400, 20), 8'($urandom), r);

        for (int i = 0; i < 4; i++) conv_a(-1, $urandom_range(400, 20), 8'(10 + i), r);
        chk("avg_10_13", a_avg, 11);
        for (int i = 0; i < 4; i++) conv_a(-1, $urandom_range(400, 20), blk200[i], r);
        chk("avg_200", a_avg, 200);
        for (int i = 0; i < 6; i++) conv_a(-1, $urandom_range(400, 20), 8'($urandom), r);

        wait_rise_a(r);
        v0 = vcnt;
        while (cyc < r + CW + TO - 1) @(negedge clk);
        chk("timeout_before", a_to, 0);
        @(negedge clk);
        chk("timeout_set", a_to, 1);
        chk("timeout_idle", a_busy, 0);
        chk("timeout_no_valid", vcnt, v0);
        conv_a(-1, 150, 8'($urandom), r2);
        chk("timeout_next_convst", r2 - r, PER);
        chk("timeout_sticky", a_to, 1);

        wait_rise_a(r);
        while (cyc < r + 50) @(negedge clk);
        a_en = 1'b0;
        blk.delete();
        @(negedge clk);
        chk("abort_busy", a_busy, 0);
        chk("abort_convst", a_convst, 0);
        v0 = vcnt;
        repeat (50) @(negedge clk);
        a_adc = 8'hEE;
        a_eoc = 1'b0;
        repeat (10) @(negedge clk);
        a_eoc = 1'b1;
        chk("abort_no_valid", vcnt, v0);
        chk("abort_data_held", a_data, last_dat);
        chk("abort_avg_held", a_avg, last_avg);
        a_en = 1'b1;
        for (int i = 0; i < 4; i++) conv_a(-1, $urandom_range(400, 20), 8'($urandom), r);
        chk("a_no_overrun", a_ovr, 0);
        a_en = 1'b0;

        @(negedge clk);
        b_en = 1'b1;
        @(negedge clk);
        chk("b_first_convst", b_convst, 1);
        r = cyc;
        while (cyc < r + 199) @(negedge clk);
        chk("b_overrun_before", b_ovr, 0);
        @(negedge clk);
        chk("b_overrun_set", b_ovr, 1);
        chk("b_still_busy", b_busy, 1);
        while (cyc < r + 300) @(negedge clk);
        bd    = 8'($urandom);
        b_adc = bd;
        b_eoc = 1'b0;
        repeat (4) @(negedge clk);
        chk("b_valid", b_valid, 1);
        chk("b_data", b_data, bd);
        chk("b_avg_valid", b_avg_valid, 1);
        chk("b_avg_eq_data", b_avg, bd);
        @(negedge clk);
        b_eoc = 1'b1;
        while (cyc < r + 399) @(negedge clk);
        chk("b_no_early_convst", b_convst, 0);
        @(negedge clk);
        chk("b_convst_400", b_convst, 1);
        chk("b_overrun_sticky", b_ovr, 1);
        chk("b_no_timeout", b_to, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_convst", b_convst, 0);
        chk("async_reset_overrun", b_ovr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/adc8_conv_sequencer.md
# adc8_conv_sequencer

Conversion initiator for the 8-bit rectifier ADCs (battery voltage and current). It drives the ADC end of the CONVST/EOC handshake: it issues a CONVST pulse at a fixed sample rate, waits for the falling EOC edge, and captures the data bus. It also produces a block average, a timeout flag and an overrun flag. One instance per ADC sits between the ADC pins and the `sensing_Vbat`/`sensing_Ibat` converters. It replaces the free-running 100 kHz CONVST and the negedge-EOC latching.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 1000: clock cycles between conversion starts (100 kHz at 100 MHz); must be ≥ CONVST_WIDTH+4.
- `CONVST_WIDTH`, 10: CONVST high time in cycles; must be ≥ 1.
- `TIMEOUT`, 500: maximum cycles spent in WAIT_EOC.
- `AVG_LOG2`, 2: the average is taken over 2^AVG_LOG2 samples; range 0..4.
- `N_BIT`, 8: ADC data width.

Ports:
- `i_CLK` in 1: single clock, 100 MHz.
- `i_RST` in 1: asynchronous, active-high reset.
- `i_enable` in 1: run conversions; low aborts any conversion in progress.
- `i_ADC_DATA` in N_BIT: ADC parallel data; stable while EOC is low.
- `i_EOC` in 1: ADC end-of-conversion, asynchronous, falls when data is ready.
- `o_CONVST` out 1: conversion start pulse to the ADC.
- `o_data` out N_BIT: last captured sample.
- `o_valid` out 1: one-cycle strobe when `o_data` is updated.
- `o_avg` out N_BIT: block average.
- `o_avg_valid` out 1: one-cycle strobe when `o_avg` is updated.
- `o_busy` out 1: high in every state except IDLE.
- `o_timeout` out 1: sticky; EOC did not fall within TIMEOUT.
- `o_overrun` out 1: sticky; a sample tick arrived while not in IDLE.

## Operation
- **Reset values:** all outputs 0. FSM in IDLE. Period counter, accumulator and sample count at 0. EOC synchronizer flops at 1.
- **EOC synchronization:** 2-flop synchronizer, then one edge register. `eoc_fall` = previous synchronized value is 1 and the current one is 0.
- **Period counter:** counts 0..SAMPLE_PERIOD-1 and wraps to 0, only while `i_enable` is high. It is held at 0 while `i_enable` is low. A tick occurs when `i_enable` is high and the counter is 0.
- **FSM states:**
  - IDLE: a tick moves to START.
  - START: `o_CONVST`=1 for exactly CONVST_WIDTH cycles, then go to WAIT_EOC.
  - WAIT_EOC:
    - `eoc_fall` moves to CAPTURE.
    - If the wait counter reaches TIMEOUT-1 with no `eoc_fall`, set `o_timeout` and return to IDLE. No sample is produced.
  - CAPTURE:
    - Register `i_ADC_DATA` into `o_data` and pulse `o_valid`.
    - Add the sample to the accumulator and increment the sample count.
    - Return to IDLE.
- **EOC edges outside WAIT_EOC** are ignored, including one that lands in the same cycle as the START→WAIT_EOC transition.
- **Tick while not IDLE:** the tick is dropped, `o_overrun` is set, and the in-progress conversion continues unaffected.
- **Averaging:**
  - The accumulator is N_BIT+AVG_LOG2 bits wide, unsigned, and cannot overflow.
  - When the count reaches 2^AVG_LOG2: `o_avg` = accumulator >> AVG_LOG2 (truncated), pulse `o_avg_valid`, then clear the accumulator and the count.
  - This happens in the same cycle that `o_valid` pulses for the last sample of the block.
  - With AVG_LOG2=0, `o_avg` equals `o_data` and the two strobes are coincident.
- **`i_enable` falling:**
  - The FSM returns to IDLE on the next edge and `o_CONVST` drops to 0.
  - The accumulator and sample count are cleared.
  - `o_data`, `o_avg` and the sticky flags are held.
- **Sticky flags** (`o_timeout`, `o_overrun`) are cleared only by `i_RST`.

## Timing
- **Enable to CONVST:** `i_enable` rises in cycle 0, giving a tick in cycle 0. The FSM is in START and `o_CONVST`=1 from cycle 1 through cycle CONVST_WIDTH.
- **Conversion spacing:** successive CONVST rising edges are exactly SAMPLE_PERIOD cycles apart when there is no overrun.
- **EOC to capture:** `i_EOC` falls before edge E.
  - `eoc_fall` is high in cycle E+2.
  - CAPTURE occurs in cycle E+3.
  - `o_valid`=1 and the new `o_data` appear in cycle E+4.
- **Outputs are registered:** all outputs come from registers, with no combinational path from any input to any output.
- **Reset:** an asynchronous assertion of `i_RST` mid-conversion drops `o_CONVST` immediately.

## Test plan
1. **Reset.** Assert `i_RST` with `i_enable`=1 and `i_EOC`=0 → all outputs stay 0 and no CONVST is issued. Deassert → first CONVST appears one cycle later and lasts 10 cycles.
2. **Single conversion.** The ADC model drops EOC 300 cycles after CONVST rises, with data 0x5A → `o_data`=0x5A and one `o_valid` pulse, 4 cycles after the EOC edge. The next CONVST rises exactly 1000 cycles after the first.
3. **Averaging.** Four samples 10, 11, 12, 13 → `o_avg`=11 (46>>2), one `o_avg_valid` pulse coincident with the fourth `o_valid`. The next block of 200, 200, 200, 201 gives `o_avg`=200.
4. **Timeout.** EOC is held high → `o_timeout` rises 500 cycles into WAIT_EOC and there is no `o_valid`. The next CONVST still fires on the following tick. EOC then falls normally → valid sample captured, `o_timeout` stays 1.
5. **Overrun.** Use SAMPLE_PERIOD=200 and EOC after 300 cycles → the tick at cycle 200 is dropped and `o_overrun`=1. The capture completes, and the next CONVST occurs at the 400 tick.
6. **Abort.** Drop `i_enable` in WAIT_EOC → `o_busy`=0 after one edge. A later EOC fall gives no `o_valid`. Re-enable and take 4 samples → the average excludes pre-abort data.
